// File: rtl/conv_window_feeder.sv
// Builds 5x5 stride-1 windows from a raster-order pixel stream using four
// circular line buffers, and hands each window to the conv engine via start/finish.
module conv_window_feeder #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     pix_in,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  output logic [25*DATA_W-1:0]  window_flat,
  output logic                  conv_start,
  input  logic                  conv_finish,
  output logic [7:0]            win_row,
  output logic [7:0]            win_col,
  output logic                  frame_done
);

  localparam int CW = $clog2(IMG_W);

  typedef enum logic [1:0] {FILL, ISSUE, WAIT, DONE} state_t;

  state_t state_reg, state_next;

  logic [7:0]        row_reg, col_reg;
  logic [7:0]        win_row_reg, win_col_reg;
  logic              pix_ready_reg, conv_start_reg, frame_done_reg, last_reg;
  logic [DATA_W-1:0] lb [4][IMG_W];
  logic [DATA_W-1:0] win [5][5];
  logic [DATA_W-1:0] col_in [5];
  logic [CW-1:0]     lb_idx;
  logic              accept, win_ok, col_end, last_pix;

  assign accept   = pix_valid && pix_ready_reg;
  assign lb_idx   = col_reg[CW-1:0];
  assign col_end  = (col_reg == 8'(IMG_W - 1));
  assign last_pix = col_end && (row_reg == 8'(IMG_H - 1));
  assign win_ok   = (row_reg >= 8'd4) && (col_reg >= 8'd4);

  // New window column, oldest row first; the incoming pixel is the newest row.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_col_in
      assign col_in[gi] = lb[gi][lb_idx];
    end
  endgenerate
  assign col_in[4] = pix_in;

  // Line buffers are never cleared; counters decide when their contents count.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < 4; k++) begin
        lb[k][lb_idx] <= col_in[k+1];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FILL:    if (accept && win_ok) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (conv_finish) state_next = last_reg ? DONE : FILL;
      DONE:    state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= FILL;
      row_reg        <= 8'd0;
      col_reg        <= 8'd0;
      win_row_reg    <= 8'd0;
      win_col_reg    <= 8'd0;
      pix_ready_reg  <= 1'b0;
      conv_start_reg <= 1'b0;
      frame_done_reg <= 1'b0;
      last_reg       <= 1'b0;
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 5; c++) begin
          win[r][c] <= '0;
        end
      end
    end else begin
      state_reg      <= state_next;
      pix_ready_reg  <= (state_next == FILL);
      conv_start_reg <= (state_next == ISSUE) || (state_next == WAIT);
      frame_done_reg <= (state_next == DONE);
      if (accept) begin
        for (int r = 0; r < 5; r++) begin
          for (int c = 0; c < 4; c++) begin
            win[r][c] <= win[r][c+1];
          end
          win[r][4] <= col_in[r];
        end
        if (col_end) begin
          col_reg <= 8'd0;
          row_reg <= last_pix ? 8'd0 : row_reg + 8'd1;
        end else begin
          col_reg <= col_reg + 8'd1;
        end
        if (win_ok) begin
          win_row_reg <= row_reg - 8'd4;
          win_col_reg <= col_reg - 8'd4;
          last_reg    <= last_pix;
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_row
      for (genvar gj = 0; gj < 5; gj++) begin : g_col
        assign window_flat[(gi*5+gj)*DATA_W +: DATA_W] = win[gi][gj];
      end
    end
  endgenerate

  assign pix_ready  = pix_ready_reg;
  assign conv_start = conv_start_reg;
  assign frame_done = frame_done_reg;
  assign win_row    = win_row_reg;
  assign win_col    = win_col_reg;

endmodule

// File: doc/conv_window_feeder.md
Name: conv_window_feeder

Overview:
- Producer side of the conv window/filter/start/finish interface. Takes a raster-order Q4.11 pixel stream and builds 5x5 sliding windows (stride 1, no padding) using four line buffers.
- Each valid window is presented to the conv engine with a start/finish handshake.
- Sits between the feature-map reader and conv. Filter loading is outside this block.

Parameters:
- IMG_W, 28, image width in pixels (>=5, <=256)
- IMG_H, 28, image height in pixels (>=5, <=256)
- DATA_W, 16, pixel width, signed Q4.11

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- pix_in  in  DATA_W  pixel data, raster order
- pix_valid  in  1  pix_in valid
- pix_ready  out  1  block accepts pixel when pix_valid&&pix_ready at posedge
- window_flat  out  25*DATA_W  window[r][c] at bits [(r*5+c)*DATA_W +: DATA_W]; r=0 oldest row, c=0 oldest column
- conv_start  out  1  window_flat valid, conv may begin
- conv_finish  in  1  conv result done for current window
- win_row  out  8  top-left row of presented window
- win_col  out  8  top-left column of presented window
- frame_done  out  1  one-cycle pulse after last window of frame finishes

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n). All outputs are registered.
- Reset values: pix_ready=0, conv_start=0, window_flat=0, win_row=0, win_col=0, frame_done=0; row/col counters=0; state=FILL.
- Line buffer contents are not cleared by reset. Validity is gated by the counters.
- Storage: 4 line buffers of IMG_W x DATA_W, circular, indexed by col. Plus a 5x5 register array.
  - On each accepted pixel, every window row shifts left one column.
  - Column 4 is loaded with {lb0[col], lb1[col], lb2[col], lb3[col], pix_in}, oldest row first.
  - The line buffers shift down at index col.
- Counters: col increments per accepted pixel and wraps IMG_W-1 -> 0 with row+1. Row wraps IMG_H-1 -> 0 at the last pixel of the frame.
- Window valid condition: the accepted pixel has row>=4 and col>=4. win_row=row-4, win_col=col-4, latched with the window.
- Windows per frame: (IMG_H-4)*(IMG_W-4); 576 at the defaults.
- FSM:
  - FILL: pix_ready=1. An accept that completes a valid window -> ISSUE. Any other accept stays in FILL.
  - ISSUE: entered on the cycle after the completing accept. conv_start=1, pix_ready=0. Go to WAIT next cycle.
  - WAIT: conv_start=1, window_flat/win_row/win_col held stable. When conv_finish is sampled 1: conv_start=0 next cycle. Next state is DONE if that window was the frame's last, else FILL.
  - DONE: frame_done=1 for exactly one cycle, pix_ready=0 -> FILL with counters at 0.
- Latency:
  - Completing accept at cycle t -> conv_start=1 at t+1.
  - conv_finish sampled at u -> conv_start=0 and pix_ready=1 at u+1 (not last window). For the last window, frame_done=1 at u+1 and pix_ready=1 at u+2.
  - conv_start is therefore low for >=1 cycle between windows, giving conv a fresh start edge.
- conv_finish outside WAIT (including ISSUE) is ignored.
- Pixels are never accepted while conv_start=1. pix_valid gaps are allowed anywhere and stall the counters.
- Reset mid-operation: abort the current window, return to FILL with counters at 0. The next accepted pixel is (row 0, col 0).
- Frames are back-to-back: pixels of the next frame are accepted from the first FILL cycle after DONE.

Test Plan:
1. IMG_W=IMG_H=8, every pixel 2048. Conv model returns finish 2 cycles after start -> exactly 16 conv_start pulses, every window element 2048. With an all-1024 filter, the conv model yields 0x6400.
2. IMG_W=IMG_H=8, pixel=row*8+col -> first window win_row=0, win_col=0, window[0][0]=0, window[4][4]=36. Second window window[0][0]=1, window[4][4]=37. Fifth window (win_row=1, win_col=0) window[0][0]=8.
3. Conv model delays finish by 10 cycles -> conv_start high 11+ cycles, window_flat unchanged, pix_ready=0 throughout. conv_start low exactly 1 cycle after finish.
4. Same frame as 2 with random pix_valid gaps (50%) -> identical window sequence and win_row/win_col sequence as scenario 2.
5. rst_n=0 for 1 cycle after 20 pixels accepted mid-frame -> all outputs 0 next cycle. A fresh ramp frame then issues its first window after the 37th accepted pixel, with window[4][4]=36.
6. Two consecutive 8x8 frames, plus a spurious conv_finish pulse while in FILL -> pulse ignored. frame_done pulses exactly twice, each 1 cycle after the 16th finish; 32 windows total.
